// File: rtl/decoder_pipe_onehot.sv
// Registered binary-to-one-hot decoder stage with valid/ready handshake.
// Optional X/Z check on accepted selects: define DECODER_PIPE_XCHECK_EN.
module decoder_pipe_onehot #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  input  logic [IN_W-1:0]  sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             xfer;
  logic             oor;
  logic             bad;
  logic             err_d;
  logic [IN_W:0]    sel_ext;
  logic [OUT_W-1:0] y_d;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // Extra bit so OUT_W == 2**IN_W still fits the compare.
  assign sel_ext = {1'b0, sel};
  assign oor     = en && (sel_ext >= (IN_W+1)'(OUT_W));

`ifdef DECODER_PIPE_XCHECK_EN
  assign bad = $isunknown({en, sel});

  always @(posedge clk) begin
    if (!rst && accept && bad)
      $display("error t=%0t sel=%b", $time, sel);
  end
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    y_d = '0;
    for (int i = 0; i < OUT_W; i++)
      y_d[i] = en && (sel == IN_W'(i));
    if (bad)
      y_d = '0;
  end

  assign err_d = oor || bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= EMPTY;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (accept) state_nx = FULL;
      FULL:  if (xfer && !accept) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (accept) begin
      y   <= y_d;
      err <= err_d;
      if (err_d && !(&err_cnt))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decoder_pipe_onehot.sv
// Scoreboard bench: two decoder configurations share one stimulus stream.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_decoder_pipe_onehot;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       en;
  logic       out_ready;
  logic [2:0] sel;

  logic       ir8, ov8, e8;
  logic [7:0] y8, c8;
  logic       ir6, ov6, e6;
  logic [5:0] y6;
  logic [1:0] c6;

  always #5 clk = ~clk;

  decoder_pipe_onehot #(.IN_W(3), .OUT_W(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir8),
    .en(en), .sel(sel),
    .out_valid(ov8), .out_ready(out_ready),
    .y(y8), .err(e8), .err_cnt(c8)
  );

  decoder_pipe_onehot #(.IN_W(3), .OUT_W(6), .CNT_W(2)) u6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir6),
    .en(en), .sel(sel),
    .out_valid(ov6), .out_ready(out_ready),
    .y(y6), .err(e6), .err_cnt(c6)
  );

  typedef struct {
    logic [7:0] y;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt8 = 0;
  int   cnt6 = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat for each configuration; u6 counter saturates at 3.
  task automatic push(logic e, logic [2:0] s);
    exp_t a;
    exp_t b;
    bit   o6;
    a.y   = e ? (8'd1 << s) : 8'd0;
    a.err = 1'b0;
    a.cnt = 8'(cnt8);
    o6    = e && (s >= 3'd6);
    if (o6 && cnt6 < 3) cnt6++;
    b.y   = (e && s < 3'd6) ? (8'd1 << s) : 8'd0;
    b.err = o6;
    b.cnt = 8'(cnt6);
    q8.push_back(a);
    q6.push_back(b);
  endtask

  task automatic send(logic e, logic [2:0] s);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    en       = e;
    sel      = s;
    for (int w = 0; w < 20 && !done; w++) begin
      @(negedge clk);
      if (ir8) begin
        push(e, s);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: sel %0d never accepted", s);
    end
  endtask

  always @(negedge clk) begin
    exp_t a;
    if (!rst) begin
      if (ov8) chk("onehot8", 32'($countones(y8) <= 1), 1);
      if (ov6) chk("onehot6", 32'($countones(y6) <= 1), 1);
      if (ov8 && out_ready) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL q8_empty: got beat y=%0h expected none", y8);
        end else begin
          a = q8.pop_front();
          chk("y8", y8, a.y);
          chk("err8", e8, a.err);
          chk("cnt8", c8, a.cnt);
        end
      end
      if (ov6 && out_ready) begin
        if (q6.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL q6_empty: got beat y=%0h expected none", y6);
        end else begin
          a = q6.pop_front();
          chk("y6", y6, a.y);
          chk("err6", e6, a.err);
          chk("cnt6", c6, a.cnt);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    en        = 1'b0;
    sel       = 3'd0;
    out_ready = 1'b1;
    #12;
    chk("rst_ov8", ov8, 0);
    chk("rst_y8", y8, 0);
    chk("rst_err8", e8, 0);
    chk("rst_cnt8", c8, 0);
    chk("rst_ov6", ov6, 0);
    chk("rst_cnt6", c6, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_inready", ir8, 1);
    @(posedge clk);
    #1;

    for (int s = 0; s < 8; s++)
      send(1'b1, 3'(s));

    send(1'b0, 3'd5);

    send(1'b1, 3'd6);
    send(1'b1, 3'd7);
    send(1'b1, 3'd2);
    send(1'b1, 3'd7);

    send(1'b1, 3'd3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    en        = 1'b1;
    sel       = 3'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_inready", ir8, 0);
      chk("stall_ov", ov8, 1);
      chk("stall_y", y8, 8'h08);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(1'b1, 3'd4);

    send(1'b1, 3'd6);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_y8", y8, 8'h40);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ov8", ov8, 0);
    chk("mid_rst_y8", y8, 0);
    chk("mid_rst_cnt6", c6, 0);
    chk("mid_rst_ov6", ov6, 0);
    q8.delete();
    q6.delete();
    cnt8 = 0;
    cnt6 = 0;
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_inready", ir8, 1);
    @(posedge clk);
    #1;

    send(1'b1, 3'd7);
    send(1'b1, 3'd0);

    repeat (3) @(negedge clk);
    chk("drain_q8", q8.size(), 0);
    chk("drain_q6", q6.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
